// File: rtl/zircon_avalon_tlc549_reader.sv
// Avalon-MM slave that sequences a TLC549 8-bit serial ADC and exposes the
// captured sample plus new/overrun/busy status over two registers.
module zircon_avalon_tlc549_reader #(
    parameter int CLK_DIV   = 25,
    parameter int CS_SETUP  = 75,
    parameter int CONV_WAIT = 1000
) (
    input  logic        csi_clk,
    input  logic        rsi_reset_n,
    input  logic        avs_address,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic        adc_cs_n,
    output logic        adc_clk,
    input  logic        adc_dout
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_DONE  = 3'd3,
        S_WAIT  = 3'd4
    } state_t;

    localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
    localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP - 1);
    localparam logic [15:0] WAIT_LAST  = 16'(CONV_WAIT - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  half_q, half_d;
    logic        adc_clk_q, adc_clk_d;
    logic        adc_cs_n_q, adc_cs_n_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        new_q, new_d;
    logic        overrun_q, overrun_d;
    logic        cont_q, cont_d;
    logic        primed_q, primed_d;
    logic        chain_q, chain_d;
    logic [31:0] rdata_q, rdata_d;
    logic        sync_meta_q, sync_q;

    logic        wr_ctrl_s, start_s, rd_data_s, busy_s;
    logic        unused_wdata_s;

    assign wr_ctrl_s      = avs_write & avs_address;
    assign start_s        = wr_ctrl_s & avs_writedata[0];
    assign rd_data_s      = avs_read & ~avs_address;
    assign busy_s         = (state_q != S_IDLE);
    assign unused_wdata_s = ^avs_writedata[31:2];

    // Next-state, sequencer outputs and register-file updates
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        half_d    = half_q;
        adc_clk_d = adc_clk_q;
        shift_d   = shift_q;
        data_d    = data_q;
        new_d     = new_q;
        overrun_d = overrun_q;
        primed_d  = primed_q;
        chain_d   = chain_q;

        if (wr_ctrl_s) begin
            cont_d = avs_writedata[1];
        end else begin
            cont_d = cont_q;
        end

        if (rd_data_s) begin
            new_d     = 1'b0;
            overrun_d = 1'b0;
        end else begin
            new_d     = new_q;
            overrun_d = overrun_q;
        end

        case (state_q)
            S_IDLE: begin
                adc_clk_d = 1'b0;
                if (start_s || cont_q) begin
                    state_d = S_SETUP;
                    cnt_d   = 16'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SETUP: begin
                // First rising edge of adc_clk coincides with entering SHIFT
                if (cnt_q == SETUP_LAST) begin
                    state_d   = S_SHIFT;
                    cnt_d     = 16'd0;
                    half_d    = 4'd0;
                    adc_clk_d = 1'b1;
                    shift_d   = {shift_q[6:0], sync_q};
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_SHIFT: begin
                if (half_q == 4'd15) begin
                    state_d   = S_DONE;
                    adc_clk_d = 1'b0;
                end else if (cnt_q == DIV_LAST) begin
                    cnt_d     = 16'd0;
                    half_d    = half_q + 4'd1;
                    adc_clk_d = ~adc_clk_q;
                    if (!adc_clk_q) begin
                        shift_d = {shift_q[6:0], sync_q};
                    end else begin
                        shift_d = shift_q;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DONE: begin
                // The ADC returns the previous conversion, so the first frame is thrown away
                if (!primed_q) begin
                    primed_d = 1'b1;
                    chain_d  = 1'b1;
                end else begin
                    data_d    = shift_q;
                    new_d     = 1'b1;
                    overrun_d = rd_data_s ? overrun_q : (overrun_q | new_q);
                end
                state_d = S_WAIT;
                cnt_d   = 16'd0;
            end
            S_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    cnt_d = 16'd0;
                    if (chain_q || cont_q) begin
                        state_d = S_SETUP;
                        chain_d = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d   = S_IDLE;
                adc_clk_d = 1'b0;
            end
        endcase

        adc_cs_n_d = ~((state_d == S_SETUP) || (state_d == S_SHIFT));

        if (avs_read) begin
            if (avs_address) begin
                rdata_d = {28'd0, cont_q, overrun_q, new_q, busy_s};
            end else begin
                rdata_d = {24'd0, data_q};
            end
        end else begin
            rdata_d = rdata_q;
        end
    end

    // State, datapath and output registers
    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 16'd0;
            half_q      <= 4'd0;
            adc_clk_q   <= 1'b0;
            adc_cs_n_q  <= 1'b1;
            shift_q     <= 8'd0;
            data_q      <= 8'd0;
            new_q       <= 1'b0;
            overrun_q   <= 1'b0;
            cont_q      <= 1'b0;
            primed_q    <= 1'b0;
            chain_q     <= 1'b0;
            rdata_q     <= 32'd0;
            sync_meta_q <= 1'b0;
            sync_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            half_q      <= half_d;
            adc_clk_q   <= adc_clk_d;
            adc_cs_n_q  <= adc_cs_n_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            new_q       <= new_d;
            overrun_q   <= overrun_d;
            cont_q      <= cont_d;
            primed_q    <= primed_d;
            chain_q     <= chain_d;
            rdata_q     <= rdata_d;
            sync_meta_q <= adc_dout;
            sync_q      <= sync_meta_q;
        end
    end

    assign avs_readdata = rdata_q;
    assign adc_cs_n     = adc_cs_n_q;
    assign adc_clk      = adc_clk_q;

endmodule
